// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED Hamming decoder engine.
// Codeword layout: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
package hamming_pkg;

    localparam int CW_W  = 16;
    localparam int MSG_W = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    localparam logic [1:0] F_NONE   = 2'b00;
    localparam logic [1:0] F_SINGLE = 2'b01;
    localparam logic [1:0] F_DOUBLE = 2'b10;

    localparam int POS_P0 = 0;
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_P4 = 4;
    localparam int POS_P8 = 8;
    localparam int POS_D1 = 3;

    // Data bits sit in every non-power-of-two position above p0.
    function automatic logic [MSG_W:1] cw_extract(
        input logic [CW_W-1:0] cw
    );
        return {cw[CW_W-1:POS_P8+1],
                cw[POS_P8-1:POS_P4+1],
                cw[POS_D1]};
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decode of one 16-bit codeword.
// Corrects a single flipped bit, flags two flipped bits.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0] cw,
    output logic [MSG_W:1]  data,
    output logic [1:0]      flag
);

    logic [3:0]      syn;
    logic            par;
    logic [CW_W-1:0] fixed;

    always_comb begin
        syn = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw[i]) begin
                syn = syn ^ 4'(i);
            end
        end
    end

    assign par = ^cw;

    always_comb begin
        fixed = cw;
        flag  = F_NONE;
        if (par) begin
            flag = F_SINGLE;
            // s == 0 means only p0 flipped; data already intact.
            if (syn != 4'd0) begin
                fixed[syn] = ~cw[syn];
            end
        end else if (syn != 4'd0) begin
            flag = F_DOUBLE;
        end
    end

    assign data = cw_extract(fixed);

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-mapped SECDED decoder: reads NUM_MSG codewords, writes results.
// Optional error counters enabled by HAMMING_DEC_STATS_EN.
module hamming_dec_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
`ifdef HAMMING_DEC_STATS_EN
    ,
    output logic [7:0] err1_cnt,
    output logic [7:0] err2_cnt
`endif
);

    state_t          state;
    logic [7:0]      k;
    logic [7:0]      off;
    logic [7:0]      cw_lo;
    logic [7:0]      res_hi;
    logic [1:0]      flag_q;
    logic [CW_W-1:0] cw;
    logic [MSG_W:1]  dec_data;
    logic [1:0]      dec_flag;
    logic            last;

    assign off  = {k[6:0], 1'b0};
    assign last = (k == 8'(NUM_MSG - 1));

    // High byte is live on the bus during RD_HI; low byte was latched.
    assign cw = {mem_rd_data, cw_lo};

    hamming_secded_dec u_dec (
        .cw   (cw),
        .data (dec_data),
        .flag (dec_flag)
    );

    always_comb begin
        mem_addr = 8'd0;
        unique case (state)
            S_RD_LO: mem_addr = 8'(SRC_BASE) + off;
            S_RD_HI: mem_addr = 8'(SRC_BASE) + off + 8'd1;
            S_WR_LO: mem_addr = 8'(DST_BASE) + off;
            S_WR_HI: mem_addr = 8'(DST_BASE) + off + 8'd1;
            default: mem_addr = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            k           <= 8'd0;
            done        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
            cw_lo       <= 8'd0;
            res_hi      <= 8'd0;
            flag_q      <= F_NONE;
`ifdef HAMMING_DEC_STATS_EN
            err1_cnt    <= 8'd0;
            err2_cnt    <= 8'd0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (req) begin
                        state <= S_RD_LO;
                        done  <= 1'b0;
                        k     <= 8'd0;
`ifdef HAMMING_DEC_STATS_EN
                        err1_cnt <= 8'd0;
                        err2_cnt <= 8'd0;
`endif
                    end
                end
                S_RD_LO: begin
                    cw_lo <= mem_rd_data;
                    state <= S_RD_HI;
                end
                S_RD_HI: begin
                    flag_q      <= dec_flag;
                    res_hi      <= {dec_flag, 3'b000,
                                    dec_data[11:9]};
                    mem_wr_data <= dec_data[8:1];
                    mem_wr_en   <= 1'b1;
                    state       <= S_WR_LO;
                end
                S_WR_LO: begin
                    mem_wr_data <= res_hi;
                    state       <= S_WR_HI;
                end
                S_WR_HI: begin
                    mem_wr_en <= 1'b0;
`ifdef HAMMING_DEC_STATS_EN
                    if (flag_q == F_SINGLE && err1_cnt != 8'hFF) begin
                        err1_cnt <= err1_cnt + 8'd1;
                    end
                    if (flag_q == F_DOUBLE && err2_cnt != 8'hFF) begin
                        err2_cnt <= err2_cnt + 8'd1;
                    end
`endif
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        k     <= k + 8'd1;
                        state <= S_RD_LO;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef HAMMING_DEC_STATS_EN
    logic unused_flag;
    assign unused_flag = ^flag_q;
`endif

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Directed bench for hamming_dec_engine with a behavioural memory.
// Stats checks compile in only when HAMMING_DEC_STATS_EN is defined.
module tb_hamming_dec_engine;

    localparam int N   = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
`ifdef HAMMING_DEC_STATS_EN
    logic [7:0] err1_cnt;
    logic [7:0] err2_cnt;
`endif

    logic [7:0]  mem [256];
    logic [15:0] scw [N];
    logic [7:0]  elo [N];
    logic [7:0]  ehi [N];
    int e1, e2;
    int pass = 0;
    int total = 0;
    int cyc;
    int n;

    hamming_dec_engine #(
        .NUM_MSG  (N),
        .SRC_BASE (SRC),
        .DST_BASE (DST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
`ifdef HAMMING_DEC_STATS_EN
        ,
        .err1_cnt    (err1_cnt),
        .err2_cnt    (err2_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] enc(input logic [10:0] m);
        logic [15:0] c;
        logic x;
        int j;
        c = '0;
        j = 0;
        for (int p = 3; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = m[j];
                j++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int p = 1; p < 16; p++) begin
                if (((p >> b) & 1) == 1 && p != (1 << b)) x ^= c[p];
            end
            c[1 << b] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] ext(input logic [15:0] c);
        logic [10:0] m;
        int j;
        m = '0;
        j = 0;
        for (int p = 3; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                m[j] = c[p];
                j++;
            end
        end
        return m;
    endfunction

    task automatic set_raw(input int k, input logic [15:0] c,
                           input logic [7:0] lo, input logic [7:0] hi);
        scw[k] = c;
        elo[k] = lo;
        ehi[k] = hi;
        mem[8'(SRC + 2 * k)]     = c[7:0];
        mem[8'(SRC + 2 * k + 1)] = c[15:8];
    endtask

    task automatic set_rand(input int k);
        logic [10:0] m;
        logic [10:0] d;
        logic [15:0] c;
        logic [1:0]  f;
        int nf, p1, p2;
        m  = 11'($urandom);
        c  = enc(m);
        nf = $urandom_range(0, 2);
        p1 = $urandom_range(0, 15);
        p2 = (p1 + $urandom_range(1, 15)) % 16;
        d  = m;
        f  = 2'b00;
        if (nf >= 1) c[p1] = ~c[p1];
        if (nf == 1) begin
            f = 2'b01;
            e1++;
        end
        if (nf == 2) begin
            c[p2] = ~c[p2];
            d = ext(c);
            f = 2'b10;
            e2++;
        end
        set_raw(k, c, d[7:0], {f, 3'b000, d[10:8]});
    endtask

    task automatic clear_dst();
        for (int i = 0; i < 2 * N; i++) mem[8'(DST + i)] = 8'hAA;
        e1 = 0;
        e2 = 0;
    endtask

    task automatic go(input bit mid, output int c);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        c = 1;
        while (!done && c < 200) begin
            @(posedge clk);
            #1 c++;
            req = mid && (c == 10 || c == 33);
        end
        req = 1'b0;
    endtask

    task automatic verify(input string run);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s lo%0d", run, k),
                  32'(mem[8'(DST + 2 * k)]), 32'(elo[k]));
            check($sformatf("%s hi%0d", run, k),
                  32'(mem[8'(DST + 2 * k + 1)]), 32'(ehi[k]));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        #1;
        check("rst done", 32'(done), 32'd0);
        check("rst wr_en", 32'(mem_wr_en), 32'd0);
        check("rst addr", 32'(mem_addr), 32'd0);
        check("rst wdata", 32'(mem_wr_data), 32'd0);
`ifdef HAMMING_DEC_STATS_EN
        check("rst err1", 32'(err1_cnt), 32'd0);
        check("rst err2", 32'(err2_cnt), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Run 1: clean all-ones codewords
        clear_dst();
        for (int k = 0; k < N; k++) set_raw(k, 16'hFFFF, 8'hFF, 8'h07);
        go(1'b0, cyc);
        check("r1 done cycle", 32'(cyc), 32'd61);
        verify("r1");
`ifdef HAMMING_DEC_STATS_EN
        check("r1 err1", 32'(err1_cnt), 32'd0);
        check("r1 err2", 32'(err2_cnt), 32'd0);
`endif
        repeat (5) @(posedge clk);
        #1 check("r1 done held", 32'(done), 32'd1);
        check("r1 idle wr_en", 32'(mem_wr_en), 32'd0);

        // Run 2: directed error cases
        clear_dst();
        set_raw(0, 16'hFFFF, 8'hFF, 8'h07);
        set_raw(1, 16'hFFFE, 8'hFF, 8'h47);
        set_raw(2, 16'h0020, 8'h00, 8'h40);
        set_raw(3, 16'h0028, 8'h03, 8'h80);
        set_raw(4, 16'h0000, 8'h00, 8'h00);
        set_raw(5, 16'h0001, 8'h00, 8'h40);
        for (int k = 6; k < N; k++) set_raw(k, 16'hFFFF, 8'hFF, 8'h07);
        go(1'b0, cyc);
        check("r2 done cycle", 32'(cyc), 32'd61);
        verify("r2");
`ifdef HAMMING_DEC_STATS_EN
        check("r2 err1", 32'(err1_cnt), 32'd3);
        check("r2 err2", 32'(err2_cnt), 32'd1);
`endif

        // Run 3: random sweep with req pulses mid-run
        clear_dst();
        for (int k = 0; k < N; k++) set_rand(k);
        go(1'b1, cyc);
        check("r3 done cycle", 32'(cyc), 32'd61);
        verify("r3");
`ifdef HAMMING_DEC_STATS_EN
        check("r3 err1", 32'(err1_cnt), 32'(e1));
        check("r3 err2", 32'(err2_cnt), 32'(e2));
`endif
        repeat (3) @(posedge clk);
        #1 check("r3 done held", 32'(done), 32'd1);

        // Run 4: reset during WR_LO of message 7, then rerun
        clear_dst();
        for (int k = 0; k < N; k++) set_rand(k);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(mem_wr_en && mem_addr == 8'(DST + 14)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("r4 reach wr_lo7", 32'(n < 100), 32'd1);
        reset = 1'b1;
        #1;
        check("r4 rst wr_en", 32'(mem_wr_en), 32'd0);
        check("r4 rst done", 32'(done), 32'd0);
        check("r4 rst addr", 32'(mem_addr), 32'd0);
`ifdef HAMMING_DEC_STATS_EN
        check("r4 rst err1", 32'(err1_cnt), 32'd0);
        check("r4 rst err2", 32'(err2_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        check("r4 lo7 unwritten", 32'(mem[8'(DST + 14)]), 32'h0AA);
        check("r4 hi6 kept", 32'(mem[8'(DST + 13)]), 32'(ehi[6]));
        @(negedge clk) reset = 1'b0;
        go(1'b0, cyc);
        check("r4 done cycle", 32'(cyc), 32'd61);
        verify("r4");
`ifdef HAMMING_DEC_STATS_EN
        check("r4 err1", 32'(err1_cnt), 32'(e1));
        check("r4 err2", 32'(err2_cnt), 32'(e2));
`endif

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
